exception_arbiter_mi: RTL and testbench



---
 rtl/exc_pkg.sv | 37 +++
 rtl/int_sync.sv | 37 +++
 rtl/exception_arbiter_mi.sv | 181 ++++++++++++++++++
 tb/tb_exception_arbiter_mi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// ----------------------------------------------------------------------------
// exc_pkg: ExcCodes, lane_exc bit positions and FSM states for the exception arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TR   = 5'h0d;

  localparam int EXC_BITS     = 9;
  localparam int EB_ADEL_IF   = 0;
  localparam int EB_ADEL_DATA = 1;
  localparam int EB_RI        = 2;
  localparam int EB_SYS       = 3;
  localparam int EB_BP        = 4;
  localparam int EB_ADES      = 5;
  localparam int EB_OV        = 6;
  localparam int EB_TR        = 7;
  localparam int EB_ERET      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/int_sync.sv
// ----------------------------------------------------------------------------
// int_sync: SYNC_STAGES-deep flop chain bringing INT_W async lines into clk.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module int_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int INT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] async_in,
  output logic [INT_W-1:0] sync_out
);

  logic [INT_W-1:0] stage_d [SYNC_STAGES];
  logic [INT_W-1:0] stage_q [SYNC_STAGES];

  always_comb begin
    stage_d[0] = async_in;
    for (int s = 1; s < SYNC_STAGES; s++) stage_d[s] = stage_q[s-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= stage_d[s];
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/exception_arbiter_mi.sv
// ----------------------------------------------------------------------------
// exception_arbiter_mi: picks the oldest excepting lane, emits a registered
// flush/redirect pulse plus CP0 commit record, then masks a refill window.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exception_arbiter_mi
  import exc_pkg::*;
#(
  parameter int          LANES       = 2,
  parameter int          INT_W       = 6,
  parameter int          SYNC_STAGES = 2,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  localparam int         LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INT_W-1:0]      ext_int,
  input  logic [LANES-1:0]      lane_valid,
  input  logic [LANES*9-1:0]    lane_exc,
  input  logic [LANES*32-1:0]   lane_pc,
  input  logic [LANES*32-1:0]   lane_addr,
  input  logic [LANES-1:0]      lane_bd,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  output logic                  flush,
  output logic [31:0]           redirect_pc,
  output logic                  except_valid,
  output logic                  eret_valid,
  output logic [4:0]            except_code,
  output logic [LW-1:0]         except_lane,
  output logic [31:0]           except_epc,
  output logic                  except_bd,
  output logic                  badv_we,
  output logic [31:0]           badvaddr,
  output logic                  busy
);

  localparam int             CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]  HOLD_LOAD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  logic [INT_W-1:0] int_s;
  logic [5:0]       int_s6;
  logic             int_req;
  logic             unused_bits;

  int_sync #(.SYNC_STAGES(SYNC_STAGES), .INT_W(INT_W)) u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ext_int),
    .sync_out (int_s)
  );

  always_comb begin
    int_s6 = '0;
    for (int k = 0; k < INT_W && k < 6; k++) int_s6[k] = int_s[k];
  end

  assign int_req = lane_valid[0] & cp0_status[0] & ~cp0_status[1] &
                   ((|(cp0_status[9:8] & cp0_cause[9:8])) |
                    (|(cp0_status[15:10] & int_s6)) |
                    (cp0_status[30] & cp0_cause[30]));

  assign unused_bits = ^{cp0_status[31], cp0_status[29:16], cp0_status[7:2],
                         cp0_cause[31], cp0_cause[29:10], cp0_cause[7:0]};

  // Scan youngest to oldest so the oldest hit lane overwrites the rest.
  logic [EXC_BITS-1:0] lane_e, win_exc;
  logic                lane_int, win_found, win_int, win_bd;
  logic [LW-1:0]       win_lane;
  logic [31:0]         win_pc, win_addr;

  always_comb begin
    lane_e = '0; lane_int = 1'b0;
    win_found = 1'b0; win_int = 1'b0; win_bd = 1'b0; win_exc = '0;
    win_lane = '0; win_pc = '0; win_addr = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      lane_e   = lane_exc[9*i +: 9];
      lane_int = (i == 0) && int_req;
      if ((lane_valid[i] && (|lane_e)) || lane_int) begin
        win_found = 1'b1;
        win_int   = lane_int;
        win_exc   = lane_e;
        win_lane  = LW'(i);
        win_pc    = lane_pc[32*i +: 32];
        win_addr  = lane_addr[32*i +: 32];
        win_bd    = lane_bd[i];
      end
    end
  end

  logic [4:0] win_code;
  logic       win_badv, win_eret;

  always_comb begin
    win_code = EXC_INT; win_badv = 1'b0; win_eret = 1'b0;
    if (win_int)                                           win_code = EXC_INT;
    else if (win_exc[EB_ADEL_IF] || win_exc[EB_ADEL_DATA]) begin win_code = EXC_ADEL; win_badv = 1'b1; end
    else if (win_exc[EB_RI])                               win_code = EXC_RI;
    else if (win_exc[EB_SYS])                              win_code = EXC_SYS;
    else if (win_exc[EB_BP])                               win_code = EXC_BP;
    else if (win_exc[EB_ADES])                             begin win_code = EXC_ADES; win_badv = 1'b1; end
    else if (win_exc[EB_OV])                               win_code = EXC_OV;
    else if (win_exc[EB_TR])                               win_code = EXC_TR;
    else                                                   win_eret = win_exc[EB_ERET];
  end

  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          flush_d, flush_q, exv_d, exv_q, eret_d, eret_q, bwe_d, bwe_q, bd_d, bd_q;
  logic [4:0]    code_d, code_q;
  logic [LW-1:0] lane_d, lane_q;
  logic [31:0]   epc_d, epc_q, badv_d, badv_q, redir_d, redir_q;

  always_comb begin
    state_d = state_q; cnt_d = cnt_q;
    flush_d = 1'b0; exv_d = 1'b0; eret_d = 1'b0; bwe_d = 1'b0;
    code_d = code_q; lane_d = lane_q; epc_d = epc_q; bd_d = bd_q;
    badv_d = badv_q; redir_d = redir_q;
    case (state_q)
      IDLE: if (win_found) begin
        state_d = FIRE;
        flush_d = 1'b1;
        exv_d   = ~win_eret;
        eret_d  = win_eret;
        bwe_d   = win_badv;
        code_d  = win_eret ? EXC_INT : win_code;
        lane_d  = win_lane;
        epc_d   = win_bd ? (win_pc - 32'd4) : win_pc;
        bd_d    = win_bd;
        badv_d  = win_exc[EB_ADEL_IF] ? win_pc : win_addr;
        redir_d = win_eret ? cp0_epc : EXC_VECTOR;
      end
      FIRE: begin
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;   cnt_q  <= '0;
      flush_q <= 1'b0;   exv_q  <= 1'b0; eret_q <= 1'b0; bwe_q <= 1'b0;
      code_q  <= '0;     lane_q <= '0;   epc_q  <= '0;   bd_q  <= 1'b0;
      badv_q  <= '0;     redir_q <= '0;
    end else begin
      state_q <= state_d; cnt_q  <= cnt_d;
      flush_q <= flush_d; exv_q  <= exv_d;  eret_q <= eret_d; bwe_q <= bwe_d;
      code_q  <= code_d;  lane_q <= lane_d; epc_q  <= epc_d;  bd_q  <= bd_d;
      badv_q  <= badv_d;  redir_q <= redir_d;
    end
  end

  assign flush        = flush_q;
  assign redirect_pc  = redir_q;
  assign except_valid = exv_q;
  assign eret_valid   = eret_q;
  assign except_code  = code_q;
  assign except_lane  = lane_q;
  assign except_epc   = epc_q;
  assign except_bd    = bd_q;
  assign badv_we      = bwe_q;
  assign badvaddr     = badv_q;
  assign busy         = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_exception_arbiter_mi.sv
// ----------------------------------------------------------------------------
// tb_exception_arbiter_mi: directed and random stimulus against a reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_exception_arbiter_mi;

  localparam int          LANES       = 2;
  localparam int          INT_W       = 6;
  localparam int          SYNC_STAGES = 2;
  localparam int          HOLD_CYCLES = 2;
  localparam logic [31:0] EXC_VECTOR  = 32'hBFC0_0380;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [INT_W-1:0]    ext_int = '0;
  logic [LANES-1:0]    lane_valid = '0;
  logic [LANES*9-1:0]  lane_exc = '0;
  logic [LANES*32-1:0] lane_pc = '0;
  logic [LANES*32-1:0] lane_addr = '0;
  logic [LANES-1:0]    lane_bd = '0;
  logic [31:0]         cp0_status = '0, cp0_cause = '0, cp0_epc = '0;

  logic        flush, except_valid, eret_valid, except_bd, badv_we, busy;
  logic [31:0] redirect_pc, except_epc, badvaddr;
  logic [4:0]  except_code;
  logic [0:0]  except_lane;

  exception_arbiter_mi #(
    .LANES(LANES), .INT_W(INT_W), .SYNC_STAGES(SYNC_STAGES),
    .HOLD_CYCLES(HOLD_CYCLES), .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk(clk), .rst(rst), .ext_int(ext_int), .lane_valid(lane_valid),
    .lane_exc(lane_exc), .lane_pc(lane_pc), .lane_addr(lane_addr), .lane_bd(lane_bd),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .flush(flush), .redirect_pc(redirect_pc), .except_valid(except_valid),
    .eret_valid(eret_valid), .except_code(except_code), .except_lane(except_lane),
    .except_epc(except_epc), .except_bd(except_bd), .badv_we(badv_we),
    .badvaddr(badvaddr), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ExcCode of the first set bit among lane_exc[7:0]; lower bit index = higher priority.
  logic [4:0] code_of [8] = '{5'h04, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h05, 5'h0c, 5'h0d};

  logic [INT_W-1:0] hist [$];
  int               mask = 0;
  logic             m_flush, m_exv, m_eret, m_bd, m_bwe, m_busy;
  logic [4:0]       m_code;
  logic [0:0]       m_lane;
  logic [31:0]      m_epc, m_badv, m_redir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    mask = 0;
    m_flush = 0; m_exv = 0; m_eret = 0; m_bd = 0; m_bwe = 0; m_busy = 0;
    m_code = '0; m_lane = '0; m_epc = '0; m_badv = '0; m_redir = '0;
  endtask

  function automatic logic int_pending(input logic [INT_W-1:0] s);
    logic pend;
    pend = 1'b0;
    for (int b = 8; b <= 9; b++) if (cp0_status[b] && cp0_cause[b]) pend = 1'b1;
    for (int k = 0; k < INT_W && k < 6; k++) if (cp0_status[10+k] && s[k]) pend = 1'b1;
    if (cp0_status[30] && cp0_cause[30]) pend = 1'b1;
    return cp0_status[0] && !cp0_status[1] && pend;
  endfunction

  task automatic model_cycle();
    logic [INT_W-1:0] s;
    logic [8:0]       e;
    logic             fired, irq;
    int               b;
    s = (hist.size() >= SYNC_STAGES) ? hist[hist.size() - SYNC_STAGES] : '0;
    m_flush = 0; m_exv = 0; m_eret = 0; m_bwe = 0; fired = 0;
    if (mask == 0) begin
      for (int i = 0; i < LANES && !fired; i++) begin
        e   = lane_exc[9*i +: 9];
        irq = (i == 0) && lane_valid[0] && int_pending(s);
        if (irq || (lane_valid[i] && e != 0)) begin
          fired   = 1;
          m_flush = 1;
          m_lane  = 1'(i);
          m_bd    = lane_bd[i];
          m_epc   = lane_pc[32*i +: 32] - (lane_bd[i] ? 32'd4 : 32'd0);
          m_badv  = e[0] ? lane_pc[32*i +: 32] : lane_addr[32*i +: 32];
          if (irq) begin
            m_exv = 1; m_code = 5'h00; m_redir = EXC_VECTOR;
          end else if (e[7:0] != 0) begin
            b = 0;
            while (!e[b]) b++;
            m_exv = 1; m_code = code_of[b]; m_redir = EXC_VECTOR;
            m_bwe = (m_code == 5'h04) || (m_code == 5'h05);
          end else begin
            m_eret = 1; m_code = 5'h00; m_redir = cp0_epc;
          end
        end
      end
      if (fired) mask = HOLD_CYCLES + 1;
    end else begin
      mask--;
    end
    m_busy = (mask >= 1) && (mask <= HOLD_CYCLES);
    hist.push_back(ext_int);
    if (hist.size() > SYNC_STAGES) void'(hist.pop_front());
  endtask

  task automatic chk_all();
    chk("flush",        32'(flush),        32'(m_flush));
    chk("except_valid", 32'(except_valid), 32'(m_exv));
    chk("eret_valid",   32'(eret_valid),   32'(m_eret));
    chk("badv_we",      32'(badv_we),      32'(m_bwe));
    chk("busy",         32'(busy),         32'(m_busy));
    chk("except_code",  32'(except_code),  32'(m_code));
    chk("except_lane",  32'(except_lane),  32'(m_lane));
    chk("except_epc",   except_epc,        m_epc);
    chk("except_bd",    32'(except_bd),    32'(m_bd));
    chk("badvaddr",     badvaddr,          m_badv);
    chk("redirect_pc",  redirect_pc,       m_redir);
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic clear_inputs();
    ext_int = '0; lane_valid = '0; lane_exc = '0; lane_pc = '0;
    lane_addr = '0; lane_bd = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) step();
  endtask

  int  lat, busy_cnt;
  logic seen;

  initial begin
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_all();
    end
    rst = 1'b1;
    idle(5);

    // Younger lane wins when the oldest is clean.
    lane_valid = 2'b11;
    lane_exc   = {9'h040, 9'h000};
    lane_pc    = {32'h8000_0104, 32'h8000_0100};
    step();
    chk("ov_flush", 32'(flush), 32'd1);
    chk("ov_code",  32'(except_code), 32'h0c);
    chk("ov_lane",  32'(except_lane), 32'd1);
    chk("ov_epc",   except_epc, 32'h8000_0104);
    chk("ov_redir", redirect_pc, 32'hBFC0_0380);
    idle(4);

    // Oldest lane wins; delay-slot EPC.
    lane_valid = 2'b11;
    lane_exc   = {9'h002, 9'h008};
    lane_bd    = 2'b01;
    lane_pc    = {32'h8000_0204, 32'h8000_0200};
    step();
    chk("sys_code", 32'(except_code), 32'h08);
    chk("sys_lane", 32'(except_lane), 32'd0);
    chk("sys_epc",  except_epc, 32'h8000_01FC);
    chk("sys_bd",   32'(except_bd), 32'd1);
    idle(4);

    // Synchronised interrupt latency.
    cp0_status = 32'h0000_0401; lane_valid = 2'b01; ext_int = 6'h01;
    lat = 0; seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      lat++;
      if (flush) seen = 1;
    end
    chk("int_latency", 32'(lat), 32'(SYNC_STAGES + 1));
    chk("int_code", 32'(except_code), 32'h00);
    idle(6);

    // EXL set blocks interrupts.
    cp0_status = 32'h0000_0403; lane_valid = 2'b01; ext_int = 6'h01;
    repeat (6) begin
      step();
      chk("exl_noflush", 32'(flush), 32'd0);
    end
    idle(6);

    // eret, then ri on both lanes during the hold window.
    lane_valid = 2'b01; lane_exc = {9'h000, 9'h100}; cp0_epc = 32'h8000_3000;
    step();
    chk("eret_valid", 32'(eret_valid), 32'd1);
    chk("eret_flush", 32'(flush), 32'd1);
    chk("eret_exv",   32'(except_valid), 32'd0);
    chk("eret_redir", redirect_pc, 32'h8000_3000);
    lane_valid = 2'b11; lane_exc = {9'h004, 9'h004};
    busy_cnt = 0; seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (busy) busy_cnt++;
      if (flush) seen = 1;
    end
    chk("hold_busy_cycles", 32'(busy_cnt), 32'(HOLD_CYCLES));
    chk("ri_after_hold", 32'(except_code), 32'h0a);
    idle(4);

    // PC wraparound in a delay slot.
    lane_valid = 2'b01; lane_exc = {9'h000, 9'h080}; lane_bd = 2'b01; lane_pc = '0;
    step();
    chk("wrap_epc", except_epc, 32'hFFFF_FFFC);
    idle(4);

    // Fetch address error, then async reset in the hold window.
    lane_valid = 2'b01; lane_exc = {9'h000, 9'h001};
    lane_pc = {32'h0, 32'h8000_0003}; lane_addr = {32'h0, 32'h1234_5678};
    step();
    chk("adelif_code", 32'(except_code), 32'h04);
    chk("adelif_bwe",  32'(badv_we), 32'd1);
    chk("adelif_badv", badvaddr, 32'h8000_0003);
    step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk_all();
    clear_inputs();
    @(posedge clk);
    #1;
    chk_all();
    rst = 1'b1;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      lane_valid = LANES'($urandom);
      lane_exc   = {9'($urandom & $urandom & $urandom), 9'($urandom & $urandom & $urandom)};
      lane_pc    = {$urandom, $urandom};
      lane_addr  = {$urandom, $urandom};
      lane_bd    = LANES'($urandom);
      ext_int    = ($urandom_range(0, 3) == 0) ? INT_W'($urandom) : '0;
      cp0_status = $urandom;
      cp0_status[0] = ($urandom_range(0, 3) != 0);
      cp0_status[1] = ($urandom_range(0, 7) == 0);
      cp0_cause  = $urandom & $urandom;
      cp0_epc    = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
